// File: rtl/mux_nx1_stream.sv
// mux_nx1_stream
// ---------------------------------------------------------------------------
// N-channel, W-bit stream multiplexer with a one-beat registered output stage.
// The granted channel is either picked by `sel` (mode=0) or found by a
// round-robin search (mode=1). The search starts just after the last served
// channel.
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous, active-high reset
//   i        packed channel data, channel k = i[k*WIDTH +: WIDTH]
//   i_valid  per-channel valid
//   i_ready  per-channel ready (combinational)
//   mode     0 = fixed select via sel, 1 = round-robin
//   sel      channel index used when mode=0 (out-of-range never grants)
//   y        registered output data
//   y_valid  output register holds a beat
//   y_ready  consumer accepts the beat in y
//   y_chan   source channel of the beat in y
//
// Handshake: a beat moves across an interface on a rising edge where both
// valid and ready are 1. A producer holds valid and data stable until that
// happens. Ready may depend on valid. Valid never depends on ready.
// ---------------------------------------------------------------------------
module mux_nx1_stream #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] i,
  input  logic [CHANNELS-1:0]       i_valid,
  output logic [CHANNELS-1:0]       i_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          y,
  output logic                      y_valid,
  input  logic                      y_ready,
  output logic [SEL_W-1:0]          y_chan
);

  logic [WIDTH-1:0] y_q, y_d;
  logic             y_valid_q, y_valid_d;
  logic [SEL_W-1:0] y_chan_q, y_chan_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;
  logic [SEL_W-1:0] cand;
  logic             load_en;
  logic             in_xfer;
  logic [WIDTH-1:0] grant_data;

  // The output register can take a new beat when it is empty, or when its
  // current beat leaves on this same edge.
  assign load_en = !y_valid_q || y_ready;

  // Grant selection.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (!mode) begin
      // For a CHANNELS value that is not a power of two, sel can name a
      // channel that does not exist. That case must never grant.
      cand = sel;
      if (int'(sel) < CHANNELS && i_valid[sel]) begin
        grant_vld = 1'b1;
        grant_idx = sel;
      end
    end else begin
      // The search visits ptr+1, ptr+2, ... and wraps. It ends with ptr
      // itself, so a lone requester that was just served wins again without
      // losing a cycle.
      for (int off = 1; off <= CHANNELS; off++) begin
        cand = SEL_W'((int'(ptr_q) + off) % CHANNELS);
        if (!grant_vld && i_valid[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  // A granted channel always has its valid set, so the grant together with
  // load_en is already the input transfer. During reset nothing is accepted.
  assign in_xfer = grant_vld && load_en && !rst;

  always_comb begin
    i_ready    = '0;
    grant_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (grant_idx == SEL_W'(k)) begin
        grant_data = i[k*WIDTH +: WIDTH];
        i_ready[k] = in_xfer;
      end
    end
  end

  // Next state of the output stage and the round-robin pointer.
  always_comb begin
    y_d       = y_q;
    y_valid_d = y_valid_q;
    y_chan_d  = y_chan_q;
    ptr_d     = ptr_q;
    if (in_xfer) begin
      // A new load replaces a draining beat, so y_valid stays high.
      y_d       = grant_data;
      y_chan_d  = grant_idx;
      y_valid_d = 1'b1;
      ptr_d     = grant_idx;
    end else if (y_valid_q && y_ready) begin
      // Only the valid flag drops. The data and channel keep their last values.
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
      y_chan_q  <= '0;
      // The pointer starts on the last channel so that channel 0 wins the
      // first round-robin search.
      ptr_q     <= SEL_W'(CHANNELS - 1);
    end else begin
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      y_chan_q  <= y_chan_d;
      ptr_q     <= ptr_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign y_chan  = y_chan_q;

endmodule

// File: tb/tb_mux_nx1_stream.sv
// tb_mux_nx1_stream
// Directed bench for mux_nx1_stream. The main instance uses the default
// configuration (4 channels, 8 bits). A second instance with 5 channels
// covers select values that name no channel. Each stimulus step pushes the
// beat it expects into exp_q. A monitor pops from exp_q whenever the DUT
// hands out a beat.
module tb_mux_nx1_stream;

  logic        clk;
  logic        rst;

  // 4-channel instance
  logic [31:0] i_data;
  logic [3:0]  i_valid;
  logic [3:0]  i_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [7:0]  y;
  logic        y_valid;
  logic        y_ready;
  logic [1:0]  y_chan;

  // 5-channel instance (select-range checks only)
  logic [39:0] i_data5;
  logic [4:0]  i_valid5;
  logic [4:0]  i_ready5;
  logic        mode5;
  logic [2:0]  sel5;
  logic [7:0]  y5;
  logic        y_valid5;
  logic        y_ready5;
  logic [2:0]  y_chan5;

  logic [7:0]  data [4];
  logic [9:0]  exp_q [$];
  int          nvec;
  int          nfail;

  mux_nx1_stream #(.WIDTH(8), .CHANNELS(4)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .i       (i_data),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .mode    (mode),
    .sel     (sel),
    .y       (y),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .y_chan  (y_chan)
  );

  mux_nx1_stream #(.WIDTH(8), .CHANNELS(5)) u_dut5 (
    .clk     (clk),
    .rst     (rst),
    .i       (i_data5),
    .i_valid (i_valid5),
    .i_ready (i_ready5),
    .mode    (mode5),
    .sel     (sel5),
    .y       (y5),
    .y_valid (y_valid5),
    .y_ready (y_ready5),
    .y_chan  (y_chan5)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: stimulus did not complete, got no end, required end");
    $fatal(1, "timeout");
  end

  // ---------------- checks ----------------
  task automatic check_vec(input string name, input logic [15:0] act,
                           input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_out(input logic v, input logic [1:0] ch, input logic [7:0] d);
    check_vec("y_valid", 16'(y_valid), 16'(v));
    check_vec("y_chan",  16'(y_chan),  16'(ch));
    check_vec("y",       16'(y),       16'(d));
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && y_valid === 1'b1 && y_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        nvec++;
        nfail++;
        $display("FAIL beat: got chan %0d data 'h%0h, expected no beat", y_chan, y);
      end else begin
        check_vec("beat", 16'({y_chan, y}), 16'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver ----------------
  // One cycle: the inputs change just after the rising edge. At the falling
  // edge i_ready is checked against the hand value, and the beat that will
  // load is queued.
  task automatic step(input logic m, input logic [1:0] s, input logic [3:0] v,
                      input logic yr, input logic [3:0] exp_rdy);
    @(posedge clk); #1;
    mode    = m;
    sel     = s;
    i_valid = v;
    y_ready = yr;
    i_data  = {data[3], data[2], data[1], data[0]};
    @(negedge clk);
    check_vec("i_ready", 16'(i_ready), 16'(exp_rdy));
    for (int k = 0; k < 4; k++)
      if (exp_rdy[k]) exp_q.push_back({2'(k), data[k]});
  endtask

  task automatic do_reset(input logic yr);
    @(posedge clk); #1;
    rst     = 1'b1;
    mode    = 1'b1;
    i_valid = 4'b1111;
    y_ready = yr;
    @(negedge clk);
    check_vec("i_ready_in_rst", 16'(i_ready), 16'h0);
    exp_q.delete();            // a held beat is discarded by reset
    @(posedge clk); #1;
    rst     = 1'b0;
    i_valid = 4'b0000;
    y_ready = 1'b1;
    @(negedge clk);
    expect_out(1'b0, 2'd0, 8'h00);
  endtask

  initial begin
    nvec     = 0;
    nfail    = 0;
    rst      = 1'b1;
    mode     = 1'b0;
    sel      = 2'd0;
    i_valid  = 4'b0000;
    y_ready  = 1'b0;
    data[0]  = 8'h3C;
    data[1]  = 8'h5A;
    data[2]  = 8'hA5;
    data[3]  = 8'hC3;
    i_data   = {data[3], data[2], data[1], data[0]};
    i_data5  = 40'h44_33_22_11_00;
    i_valid5 = 5'b00000;
    mode5    = 1'b0;
    sel5     = 3'd0;
    y_ready5 = 1'b1;

    repeat (2) @(posedge clk);
    do_reset(1'b1);

    // fixed mode, channel 2
    step(1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100);
    // sel=1 but channel 1 is idle: no grant, y_valid drops
    step(1'b0, 2'd1, 4'b1101, 1'b1, 4'b0000);
    // sel=3 transfer; the outputs still show the drained beat (A5, chan 2)
    step(1'b0, 2'd3, 4'b1000, 1'b1, 4'b1000);
    expect_out(1'b0, 2'd2, 8'hA5);

    // round robin after ptr=3: 0,1,2,3,0,1
    step(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001);
    expect_out(1'b1, 2'd3, 8'hC3);
    step(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010);
    step(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100);
    step(1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000);
    step(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001);
    step(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010);

    // backpressure: channel 2 loads, then 3 stall cycles
    step(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100);
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000);
      expect_out(1'b1, 2'd2, 8'hA5);
    end
    // release: channel 3 is next, then channel 0
    step(1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000);
    step(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001);

    // single requester in round robin: granted on every cycle, with new data
    step(1'b1, 2'd0, 4'b0010, 1'b1, 4'b0010);
    data[1] = 8'h77;
    step(1'b1, 2'd0, 4'b0010, 1'b1, 4'b0010);
    data[1] = 8'h18;
    step(1'b1, 2'd0, 4'b0010, 1'b1, 4'b0010);
    expect_out(1'b1, 2'd1, 8'h77);

    // fixed select of an idle channel: no grant
    step(1'b0, 2'd0, 4'b1110, 1'b1, 4'b0000);

    // 5-channel instance: sel 5..7 never grant, sel 4 does
    i_valid5 = 5'b11111;
    sel5     = 3'd5;
    #1 check_vec("i_ready5_sel5", 16'(i_ready5), 16'h00);
    sel5     = 3'd6;
    #1 check_vec("i_ready5_sel6", 16'(i_ready5), 16'h00);
    sel5     = 3'd7;
    #1 check_vec("i_ready5_sel7", 16'(i_ready5), 16'h00);
    sel5     = 3'd4;
    #1 check_vec("i_ready5_sel4", 16'(i_ready5), 16'h10);
    i_valid5 = 5'b00000;

    // reset while a beat is held under backpressure (ptr=1, so channel 2 wins)
    step(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100);
    step(1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000);
    do_reset(1'b0);
    // after reset channel 0 has first priority
    step(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001);
    step(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000);
    expect_out(1'b1, 2'd0, 8'h3C);

    // drain, then confirm every expected beat came out
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_vec("exp_q_empty", 16'(exp_q.size()), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
